// File: rtl/ps2_key_event_queue_if.sv
// Bus between the scancode receiver / CPU side and the key event queue.
// The queue takes the slave modport; the driver of bytes and pops takes master.
interface ps2_key_event_queue_if #(
  parameter int FIFO_DEPTH = 16
);
  logic [7:0]                  scancode;
  logic                        scancode_ready;
  logic                        rd_pop;
  logic                        clear_overflow;
  logic                        rd_valid;
  logic [9:0]                  rd_data;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic                        overflow;
  logic [5:0]                  modifiers;

  modport master (
    output scancode, scancode_ready, rd_pop, clear_overflow,
    input  rd_valid, rd_data, count, overflow, modifiers
  );

  modport slave (
    input  scancode, scancode_ready, rd_pop, clear_overflow,
    output rd_valid, rd_data, count, overflow, modifiers
  );
endinterface

// File: rtl/ps2_key_event_queue.sv
// Folds PS/2 Set 2 prefix sequences into {ext, rel, code} events, tracks modifiers
// and queues events in a circular FIFO popped by the CPU.
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH = 16,
  parameter int PAUSE_LEN  = 7
) (
  input  logic                 CLOCK_50,
  input  logic                 rst_n,
  ps2_key_event_queue_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PAUSE_LEN + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_REL     = 3'd2;
  localparam logic [2:0] S_EXT_REL = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    mod_q, mod_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [9:0]    mem_q [FIFO_DEPTH];

  logic [7:0] sc;
  logic       is_prefix, from_idle;
  logic       emit, ev_ext, ev_rel;
  logic       full, pop, wr_en, drop;

  assign sc        = bus.scancode;
  assign is_prefix = (sc == 8'hE0) || (sc == 8'hF0) || (sc == 8'hE1);
  // A prefix arriving while a release is pending starts a fresh sequence.
  assign from_idle = (state_q == S_IDLE) ||
                     (((state_q == S_REL) || (state_q == S_EXT_REL)) && is_prefix);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    ev_ext  = 1'b0;
    ev_rel  = 1'b0;
    if (bus.scancode_ready) begin
      if (from_idle) begin
        case (sc)
          8'hE0: state_d = S_EXT;
          8'hF0: state_d = S_REL;
          8'hE1: begin
            state_d = S_PAUSE;
            cnt_d   = CW'(PAUSE_LEN);
          end
          8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_d = S_IDLE;
          default: begin
            state_d = S_IDLE;
            emit    = 1'b1;
          end
        endcase
      end else begin
        case (state_q)
          S_EXT: begin
            if (sc == 8'hF0) state_d = S_EXT_REL;
            else if (sc != 8'hE0) begin
              emit    = 1'b1;
              ev_ext  = 1'b1;
              state_d = S_IDLE;
            end
          end
          S_REL, S_EXT_REL: begin
            emit    = 1'b1;
            ev_ext  = (state_q == S_EXT_REL);
            ev_rel  = 1'b1;
            state_d = S_IDLE;
          end
          S_PAUSE: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              emit    = 1'b1;
              ev_ext  = 1'b1;
              state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // The pause event carries E1 as its code; every other event carries the byte.
  logic [7:0] ev_code;
  logic [9:0] ev_word;
  assign ev_code = (state_q == S_PAUSE) ? 8'hE1 : sc;
  assign ev_word = {ev_ext, ev_rel, ev_code};

  always_comb begin
    mod_d = mod_q;
    if (emit) begin
      case ({ev_ext, ev_code})
        9'h012:  mod_d[0] = ~ev_rel;
        9'h059:  mod_d[1] = ~ev_rel;
        9'h014:  mod_d[2] = ~ev_rel;
        9'h114:  mod_d[3] = ~ev_rel;
        9'h011:  mod_d[4] = ~ev_rel;
        9'h111:  mod_d[5] = ~ev_rel;
        default: mod_d    = mod_q;
      endcase
    end
  end

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = bus.rd_pop && (count_q != '0);
  assign wr_en = emit && (!full || pop);
  assign drop  = emit && full && !pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (bus.clear_overflow) ovf_d = 1'b0;
    if (drop)               ovf_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mod_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= ev_word;
    end
  end

  assign bus.rd_valid  = (count_q != '0);
  assign bus.rd_data   = mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.modifiers = mod_q;
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench: event-level model (byte -> event rules, queue of events) checked
// against the queue every cycle, plus hand-computed literal expectations.
module tb_ps2_key_event_queue;
  localparam int DEPTH = 16;
  localparam int PLEN  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_event_queue_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_key_event_queue #(.FIFO_DEPTH(DEPTH), .PAUSE_LEN(PLEN)) dut (
    .CLOCK_50(clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [9:0] mq[$];
  logic [5:0] mmod;
  logic       movf;
  bit         ext_p, rel_p;
  int         pause_left;

  function automatic int mod_index(input bit e, input logic [7:0] c);
    if (!e && c == 8'h12) return 0;
    if (!e && c == 8'h59) return 1;
    if (!e && c == 8'h14) return 2;
    if ( e && c == 8'h14) return 3;
    if (!e && c == 8'h11) return 4;
    if ( e && c == 8'h11) return 5;
    return -1;
  endfunction

  task automatic m_emit(input bit e, input bit r, input logic [7:0] c);
    int k;
    k = mod_index(e, c);
    if (k >= 0) mmod[k] = !r;
    if (mq.size() < DEPTH) mq.push_back({e, r, c});
    else movf = 1'b1;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (pause_left > 0) begin
      pause_left--;
      if (pause_left == 0) m_emit(1'b1, 1'b0, 8'hE1);
    end else if (rel_p && (b == 8'hE0 || b == 8'hF0 || b == 8'hE1)) begin
      ext_p = (b == 8'hE0);
      rel_p = (b == 8'hF0);
      if (b == 8'hE1) pause_left = PLEN;
    end else if (rel_p) begin
      m_emit(ext_p, 1'b1, b);
      ext_p = 0; rel_p = 0;
    end else if (ext_p) begin
      if (b == 8'hF0) rel_p = 1;
      else if (b != 8'hE0) begin
        m_emit(1'b1, 1'b0, b);
        ext_p = 0;
      end
    end else begin
      case (b)
        8'hE0: ext_p = 1;
        8'hF0: rel_p = 1;
        8'hE1: pause_left = PLEN;
        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
        default: m_emit(1'b0, 1'b0, b);
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mmod = '0; movf = 1'b0; ext_p = 0; rel_p = 0; pause_left = 0;
    end else begin
      if (bus.rd_pop && mq.size() > 0) void'(mq.pop_front());
      if (bus.clear_overflow) movf = 1'b0;
      if (bus.scancode_ready) m_byte(bus.scancode);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    cmp("rd_valid",  32'(bus.rd_valid),  32'(mq.size() > 0));
    cmp("count",     32'(bus.count),     32'(mq.size()));
    cmp("overflow",  32'(bus.overflow),  32'(movf));
    cmp("modifiers", 32'(bus.modifiers), 32'(mmod));
    if (mq.size() > 0) cmp("rd_data", 32'(bus.rd_data), 32'(mq[0]));
    else if (!rst_n)   cmp("rd_data_rst", 32'(bus.rd_data), 32'h0);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] b, input logic r, input logic p, input logic c);
    bus.scancode       = b;
    bus.scancode_ready = r;
    bus.rd_pop         = p;
    bus.clear_overflow = c;
    @(posedge clk); #1;
    bus.scancode_ready = 1'b0;
    bus.rd_pop         = 1'b0;
    bus.clear_overflow = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    drive(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    repeat (DEPTH + 1) if (bus.count != 0) pop1();
  endtask

  initial begin
    bus.scancode = '0; bus.scancode_ready = 0; bus.rd_pop = 0; bus.clear_overflow = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_count", 32'(bus.count), 0);
    cmp("rst_valid", 32'(bus.rd_valid), 0);
    cmp("rst_mods",  32'(bus.modifiers), 0);
    cmp("rst_ovf",   32'(bus.overflow), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // plain make / break, one-cycle latency
    send(8'h1C);
    cmp("lat_valid", 32'(bus.rd_valid), 1);
    cmp("make_1C", 32'(bus.rd_data), 32'h01C);
    send(8'hF0); send(8'h1C);
    cmp("count2", 32'(bus.count), 2);
    cmp("mods_unchanged", 32'(bus.modifiers), 0);
    pop1();
    cmp("break_1C", 32'(bus.rd_data), 32'h11C);
    pop1(); pop1();
    cmp("pop_empty", 32'(bus.count), 0);

    // extended make / break and modifiers (back-to-back strobes)
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    cmp("ext_make", 32'(bus.rd_data), 32'h275);
    pop1();
    cmp("ext_break", 32'(bus.rd_data), 32'h375);
    send(8'h12);
    cmp("lshift", 32'(bus.modifiers), 32'h01);
    send(8'hE0); send(8'h14);
    cmp("rctrl", 32'(bus.modifiers), 32'h09);
    send(8'hE0); send(8'hF0); send(8'h14);
    cmp("rctrl_rel", 32'(bus.modifiers), 32'h01);
    send(8'hF0); send(8'h12);
    send(8'h11); send(8'hE0); send(8'h11);
    cmp("alts", 32'(bus.modifiers), 32'h30);
    send(8'hF0); send(8'hE0); send(8'hF0); send(8'h11);  // F0 then prefix restarts
    cmp("ralt_rel", 32'(bus.modifiers), 32'h10);
    drain();

    // pause sequence, then discarded bytes
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    cmp("pause_count", 32'(bus.count), 1);
    cmp("pause_data", 32'(bus.rd_data), 32'h2E1);
    send(8'hAA); send(8'hFA);
    cmp("discard", 32'(bus.count), 1);
    send(8'h1C);
    cmp("idle_after_pause", 32'(bus.count), 2);
    drain();

    // overflow
    for (int i = 0; i < 17; i++) send(8'h20 + 8'(i));
    cmp("full_count", 32'(bus.count), 16);
    cmp("ovf_set", 32'(bus.overflow), 1);
    cmp("head_first", 32'(bus.rd_data), 32'h020);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    cmp("ovf_clr", 32'(bus.overflow), 0);
    drive(8'h50, 1'b1, 1'b0, 1'b1);
    cmp("ovf_set_wins", 32'(bus.overflow), 1);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'h31, 1'b1, 1'b1, 1'b0);
    cmp("pushpop_full", 32'(bus.count), 16);
    cmp("pushpop_head", 32'(bus.rd_data), 32'h021);
    repeat (15) pop1();
    cmp("tail_newest", 32'(bus.rd_data), 32'h031);
    drain();

    // reset mid-sequence
    send(8'h12); send(8'h33); send(8'hE0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp("rst_mid_count", 32'(bus.count), 0);
    cmp("rst_mid_mods", 32'(bus.modifiers), 0);
    send(8'h1C);
    cmp("rst_mid_byte", 32'(bus.rd_data), 32'h01C);
    pop1();
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
